// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice and a registered
// carry, LSB first, behind a START/DONE handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic            c;
  logic            sum;
  logic            carry;

  always_comb begin
    sum   = a_sh[0] ^ b_sh[0] ^ c;
    carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      c     <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      OVF   <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (START) begin
            // Subtraction as A + ~B + ~Cin: invert B and the incoming carry.
            a_sh  <= A;
            b_sh  <= B ^ {WIDTH{SUB}};
            c     <= Cin ^ SUB;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= {sum, r_sh[WIDTH-1:1]};
          c    <= carry;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // c is the carry into the MSB here; overflow is carry-in XOR carry-out.
            S     <= {sum, r_sh[WIDTH-1:1]};
            Cout  <= carry;
            OVF   <= c ^ carry;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder at WIDTH=8 and WIDTH=4.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] s8;
  logic       start4, cin4, sub4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] s4;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .START(start8), .A(a8), .B(b8), .Cin(cin8), .SUB(sub8),
    .BUSY(busy8), .DONE(done8), .S(s8), .Cout(cout8), .OVF(ovf8)
  );

  serial_adder #(.WIDTH(4)) u4 (
    .CLK(clk), .RST(rst), .START(start4), .A(a4), .B(b4), .Cin(cin4), .SUB(sub4),
    .BUSY(busy4), .DONE(done4), .S(s4), .Cout(cout4), .OVF(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic start_op4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sb);
    a4 = a; b4 = b; cin4 = ci; sub4 = sb; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  // Edges from the current point until DONE is seen; 99 if it never arrives.
  task automatic wait_done8(output int n);
    n = 99;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done8) begin n = i; break; end
    end
  endtask

  task automatic wait_done4(output int n);
    n = 99;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done4) begin n = i; break; end
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    chk({tag, ".S"}, 32'(s8), 32'(es));
    chk({tag, ".Cout"}, 32'(cout8), 32'(ec));
    chk({tag, ".OVF"}, 32'(ovf8), 32'(eo));
  endtask

  // Reference: signed and unsigned integer arithmetic, reduced modulo 2^w.
  function automatic void model(input int w, input int a, input int b, input int ci, input int sb,
                                output int s, output int co, output int ov);
    int m, sa, sbv, u, sv;
    m   = 1 << w;
    sa  = (a >= m / 2) ? a - m : a;
    sbv = (b >= m / 2) ? b - m : b;
    if (sb == 0) begin
      u  = a + b + ci;
      sv = sa + sbv + ci;
      co = (u >= m) ? 1 : 0;
    end else begin
      u  = a - b - ci;
      sv = sa - sbv - ci;
      co = (u >= 0) ? 1 : 0;
    end
    s  = ((u % m) + m) % m;
    ov = (sv > m / 2 - 1 || sv < -(m / 2)) ? 1 : 0;
  endfunction

  initial begin
    int n, n2, seen, es, ec, eo;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.BUSY", 32'(busy8), 32'd0);
    chk("rst.DONE", 32'(done8), 32'd0);
    check8("rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic add with latency check
    start_op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    chk("add1.BUSY", 32'(busy8), 32'd1);
    wait_done8(n);
    chk("add1.lat", 32'(n), 32'd8);
    chk("add1.BUSYfin", 32'(busy8), 32'd0);
    check8("add1", 8'h96, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("add1.DONEpulse", 32'(done8), 32'd0);
    check8("add1.hold", 8'h96, 1'b0, 1'b1);

    start_op8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done8(n);
    check8("add2", 8'h00, 1'b1, 1'b0);

    start_op8(8'h7F, 8'h00, 1'b1, 1'b0);
    wait_done8(n);
    check8("add3", 8'h80, 1'b0, 1'b1);

    start_op8(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done8(n);
    check8("sub1", 8'hF0, 1'b0, 1'b0);

    start_op8(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done8(n);
    check8("sub2", 8'h7F, 1'b1, 1'b1);

    // START and operand changes mid-run are ignored
    @(posedge clk); #1;
    start_op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'h00; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(n);
    chk("midrun.lat", 32'(n + 4), 32'd8);
    check8("midrun", 8'h96, 1'b0, 1'b1);

    // Back-to-back: START in the FIN cycle
    start_op8(8'h10, 8'h20, 1'b0, 1'b1);
    chk("b2b.DONEdrop", 32'(done8), 32'd0);
    chk("b2b.BUSY", 32'(busy8), 32'd1);
    wait_done8(n);
    chk("b2b.spacing", 32'(n + 1), 32'd9);
    check8("b2b", 8'hF0, 1'b0, 1'b0);

    // Reset at bit 3 aborts without a DONE pulse
    @(posedge clk); #1;
    start_op8(8'h7F, 8'h00, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.BUSY", 32'(busy8), 32'd0);
    chk("abort.DONE", 32'(done8), 32'd0);
    check8("abort", 8'h00, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen++;
    end
    chk("abort.quiet", 32'(seen), 32'd0);
    start_op8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done8(n);
    chk("postrst.lat", 32'(n), 32'd8);
    check8("postrst", 8'h00, 1'b1, 1'b0);

    // WIDTH=4 directed
    start_op4(4'h9, 4'h9, 1'b0, 1'b0);
    wait_done4(n);
    chk("w4.lat", 32'(n), 32'd4);
    chk("w4.S", 32'(s4), 32'h2);
    chk("w4.Cout", 32'(cout4), 32'd1);
    chk("w4.OVF", 32'(ovf4), 32'd1);

    // WIDTH=4 exhaustive against the integer reference
    n2 = 0;
    for (int sb = 0; sb < 2; sb++)
      for (int ci = 0; ci < 2; ci++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            start_op4(4'(a), 4'(b), 1'(ci), 1'(sb));
            wait_done4(n);
            model(4, a, b, ci, sb, es, ec, eo);
            if (n != 4) n2++;
            chk("w4x.S", 32'(s4), 32'(es));
            chk("w4x.Cout", 32'(cout4), 32'(ec));
            chk("w4x.OVF", 32'(ovf4), 32'(eo));
          end
    chk("w4x.latency_errors", 32'(n2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor that generalises the ripple full adder to WIDTH-bit operands. It uses one full-adder slice plus a registered carry and processes one bit per clock, LSB first. The block sits behind a START/DONE handshake, so datapath blocks can trade latency for area. Outputs are the sum, the carry/borrow, and a signed-overflow flag.

## Interface
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.
- CLK  in  1  sole clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only when BUSY=0.
- A  in  WIDTH  first operand; sampled on the accepting edge.
- B  in  WIDTH  second operand; sampled on the accepting edge.
- Cin  in  1  carry-in (SUB=0) or borrow-in (SUB=1); sampled on the accepting edge.
- SUB  in  1  0: S = A + B + Cin; 1: S = A - B - Cin. Sampled on the accepting edge.
- BUSY  out  1  high while bits are being processed.
- DONE  out  1  one-cycle pulse when a result is valid.
- S  out  WIDTH  result; held between operations.
- Cout  out  1  carry out of the MSB; in SUB mode, 1 means no borrow.
- OVF  out  1  two's-complement overflow of the operation.

## Operation
- States: IDLE, RUN, FIN.
- Reset (RST=1 at an edge, which has priority over everything):
  - state goes to IDLE;
  - S, Cout, OVF, BUSY, DONE all clear to 0;
  - bit counter and shift registers clear to 0.
- Accept in IDLE or FIN when START=1:
  - load a_sh = A and b_sh = B XOR {WIDTH{SUB}};
  - carry register c = Cin XOR SUB;
  - counter = 0; go to RUN.
- RUN, each edge:
  - compute sum bit = a_sh[0] ^ b_sh[0] ^ c;
  - compute carry = majority(a_sh[0], b_sh[0], c);
  - shift a_sh and b_sh right by 1;
  - shift the sum bit into the MSB of r_sh;
  - update c; counter++.
- Last bit (counter == WIDTH-1):
  - latch the carry entering that bit as c_msb;
  - on the same edge load S = final r_sh, Cout = carry out, OVF = c_msb XOR carry out;
  - go to FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE. START in FIN is accepted (back-to-back) and goes straight to RUN.
- START while BUSY=1 is ignored. Operand input changes during RUN have no effect.
- S, Cout and OVF change only on completion or reset. They are never partial during RUN.
- RST during RUN aborts the operation: no DONE pulse, and outputs clear to 0.
- Arithmetic is modulo 2^WIDTH. No internal width beyond WIDTH+1 carry bits.

## Timing
- Accepting edge k: BUSY=1 from after edge k until after edge k+WIDTH.
- After edge k+WIDTH: BUSY=0, DONE=1, and S/Cout/OVF are valid.
- After edge k+WIDTH+1: DONE=0 unless a new operation completes. Results stay held.
- Latency is WIDTH cycles from accept to DONE. Peak throughput is one operation per WIDTH+1 cycles.
- BUSY is 0 in the FIN cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, Cin=0, SUB=0 -> DONE exactly 8 cycles after accept, S=0x96, Cout=0, OVF=1.
- WIDTH=8, A=0xFF, B=0x01, Cin=0, SUB=0 -> S=0x00, Cout=1, OVF=0. Also A=0x7F, B=0x00, Cin=1 -> S=0x80, Cout=0, OVF=1.
- WIDTH=8, SUB=1, Cin=0:
  - A=0x10, B=0x20 -> S=0xF0, Cout=0, OVF=0;
  - A=0x80, B=0x01 -> S=0x7F, Cout=1, OVF=1.
- START pulsed and A changed mid-RUN -> both ignored, and the original result is produced. START asserted in the FIN cycle -> second op accepted with no IDLE gap, and the second DONE comes WIDTH+1 cycles after the first.
- RST asserted at bit 3 of a run -> next cycle: all outputs 0, no DONE pulse. A new START after RST is released completes correctly.
- WIDTH=4, A=0x9, B=0x9, Cin=0, SUB=0 -> DONE after 4 cycles, S=0x2, Cout=1, OVF=1. Exhaustive random compare against A±B±Cin for WIDTH=4.
